display_driver_module: RTL
==========================

DISPLAY_DRIVER_MODULE -- requirements
Module: display_driver_module

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit scan slot, minimum 2.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port value_i  input  8  unsigned byte to display, from the output register.
REQ-005 SHALL have port load_i  input  1  single-cycle strobe meaning value_i is valid (driven from OUI).
REQ-006 SHALL have port busy_o  output  1  high while a conversion is in progress.
REQ-007 SHALL have port seg_o  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-008 SHALL have port an_o  output  3  active-low digit enables; bit0 ones, bit1 tens, bit2 hundreds.

Function
REQ-009 SHALL convert value_i to three BCD digits by sequential shift-add-3, one bit per clk.
REQ-010 SHALL use FSM states IDLE, CONVERT, COMMIT: IDLE + load_i -> CONVERT; CONVERT stays 8 cycles -> COMMIT; COMMIT -> IDLE, or -> CONVERT if a value is pending.
REQ-011 SHALL capture value_i on the edge load_i is sampled (E0), shift on E1..E8, and write the display register on E9.
REQ-012 SHALL drive busy_o high from after E0 until after E9, and low in IDLE.
REQ-013 SHALL hold one pending byte: load_i while not IDLE stores value_i in the pending register, overwriting any older pending value.
REQ-014 SHALL, in COMMIT with a pending value, start its conversion on the next edge and clear the pending flag.
REQ-015 SHALL, when load_i coincides with COMMIT, treat the new value as pending; a value already pending is overwritten.
REQ-016 SHALL change the display register only in COMMIT, so the displayed digits never show partial results.
REQ-017 SHALL count a prescaler 0..SCAN_DIV-1 and advance the digit index 0->1->2->0 at terminal count, wrapping the prescaler to 0.
REQ-018 SHALL drive an_o with exactly one bit low, selecting the current digit index, and drive seg_o with that digit's pattern.
REQ-019 SHALL use patterns 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 blank=1111111.
REQ-020 SHALL keep the scan running regardless of FSM state.
REQ-021 SHALL register seg_o and an_o so both change on the same edge.

Reset
REQ-022 SHALL on rst set: FSM IDLE, busy_o 0, pending flag 0, display register 000, prescaler 0, digit index 0, an_o 110, seg_o 1000000.
REQ-023 SHALL abort a conversion in progress on rst without updating the display register.
REQ-024 SHALL ignore load_i while rst is high.

Configuration
REQ-025 SHALL, with macro DISPLAY_LEADING_ZERO_BLANK_EN defined, blank the hundreds digit when it is 0, and blank the tens digit when hundreds and tens are both 0.
REQ-026 SHALL, without DISPLAY_LEADING_ZERO_BLANK_EN, show all three digits including leading zeros.
REQ-027 SHALL never blank the ones digit, in either configuration.

Structure
REQ-028 SHALL place the segment pattern constants, the digit count (3) and the FSM state encodings in global.vh.
REQ-029 SHALL place BCD-to-segment decoding in one combinational sub-module, seg_decoder_module.

Verification (SCAN_DIV=4)
REQ-030 SHALL check: rst pulse -> busy_o 0, an_o 110, seg_o 1000000 immediately, without waiting for a clk edge.
REQ-031 SHALL check: load_i with value_i=8'd173 -> busy_o high for 9 cycles; then scan shows ones 3 (0110000), tens 7 (1111000), hundreds 1 (1111001), each for 4 cycles.
REQ-032 SHALL check: load 8'd5 -> digits 5, 0, 0 without the macro; with the macro -> 5, blank, blank.
REQ-033 SHALL check: load 8'd255, then 8'd10 at E3, then 8'd42 at E5 -> display shows 255, then 042; 10 is never displayed; busy_o stays high through both conversions.
REQ-034 SHALL check: rst asserted at E4 of loading 8'd99 -> display 000 after reset, busy_o 0, no commit.
REQ-035 SHALL check: load coincident with COMMIT of 8'd1, new value 8'd200 -> 001 committed, then 200 committed 9 cycles later.

Source files
------------

// File: rtl/display_driver_module_pkg.sv
// Shared constants for the byte-to-7-segment display driver: digit count,
// FSM state encodings and active-low segment patterns ({g,f,e,d,c,b,a}).
package display_driver_module_pkg;

    localparam int NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/display_driver_module_seg_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; codes above 9 blank.
module seg_decoder_module (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    import display_driver_module_pkg::*;

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_driver_module.sv
// Byte to 3-digit multiplexed 7-segment driver with sequential shift-add-3 conversion.
// Define DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zeros in hundreds/tens.
module display_driver_module #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value_i,
    input  logic       load_i,
    output logic       busy_o,
    output logic [6:0] seg_o,
    output logic [2:0] an_o
);
    import display_driver_module_pkg::*;

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    state_t      state;
    logic [2:0]  bit_cnt;
    logic        pend_vld;
    logic [7:0]  pend_val;
    logic [7:0]  bin_sr;
    logic [11:0] bcd_sr;
    logic [11:0] disp;
    logic [PW-1:0] prescale;
    logic [1:0]  digit_idx;

    logic        start;
    logic [7:0]  start_val;
    logic [11:0] disp_next;
    logic [1:0]  idx_next;
    logic [3:0]  digit_sel;
    logic [6:0]  seg_next;
    logic [2:0]  an_next;

    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // A load arriving during COMMIT supersedes any older pending byte and starts at once.
    assign start     = (state == IDLE && load_i) || (state == COMMIT && (load_i || pend_vld));
    assign start_val = (state == COMMIT && !load_i) ? pend_val : value_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            pend_vld <= 1'b0;
            bit_cnt  <= 3'd0;
            disp     <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_i) begin
                        state   <= CONVERT;
                        busy_o  <= 1'b1;
                        bit_cnt <= 3'd0;
                    end
                end
                CONVERT: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (load_i)
                        pend_vld <= 1'b1;
                    if (bit_cnt == 3'd7)
                        state <= COMMIT;
                end
                COMMIT: begin
                    disp <= bcd_sr;
                    if (load_i || pend_vld) begin
                        state    <= CONVERT;
                        bit_cnt  <= 3'd0;
                        pend_vld <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_i && state != IDLE)
            pend_val <= value_i;
        if (start) begin
            bin_sr <= start_val;
            bcd_sr <= 12'd0;
        end else if (state == CONVERT) begin
            {bcd_sr, bin_sr} <= {add3(bcd_sr), bin_sr} << 1;
        end
    end

    // Outputs are registered from next-state values so an_o/seg_o track the digit index.
    assign disp_next = (state == COMMIT) ? bcd_sr : disp;
    assign idx_next  = (prescale == PRE_MAX) ? ((digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1)
                                             : digit_idx;

    always_comb begin
        digit_sel = disp_next[3:0];
        an_next   = 3'b110;
        case (idx_next)
            2'd1: begin
                an_next   = 3'b101;
                digit_sel = disp_next[7:4];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
                if (disp_next[11:4] == 8'd0)
                    digit_sel = DIGIT_BLANK;
`endif
            end
            2'd2: begin
                an_next   = 3'b011;
                digit_sel = disp_next[11:8];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
                if (disp_next[11:8] == 4'd0)
                    digit_sel = DIGIT_BLANK;
`endif
            end
            default: begin
                an_next   = 3'b110;
                digit_sel = disp_next[3:0];
            end
        endcase
    end

    seg_decoder_module u_seg_decoder (
        .digit (digit_sel),
        .seg   (seg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale  <= '0;
            digit_idx <= 2'd0;
            an_o      <= 3'b110;
            seg_o     <= SEG_0;
        end else begin
            prescale  <= (prescale == PRE_MAX) ? '0 : prescale + PW'(1);
            digit_idx <= idx_next;
            an_o      <= an_next;
            seg_o     <= seg_next;
        end
    end

endmodule
